// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  // Iteration counter width for an arbitrary operand width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_addsub_step.sv
// One non-restoring step: R -/+ D on a WIDTH+1-bit signed partial remainder.
module div_addsub_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   r_in,
  input  logic        [WIDTH-1:0] d,
  input  logic                    sub,
  output logic signed [WIDTH:0]   r_out,
  output logic                    q_bit
);

  logic signed [WIDTH:0] d_ext;

  always_comb begin
    d_ext = signed'({1'b0, d});
    r_out = sub ? (r_in - d_ext) : (r_in + d_ext);
    q_bit = ~r_out[WIDTH];
  end

endmodule

// File: rtl/div_seq_32b.sv
// Multi-cycle non-restoring divider, one quotient bit per clock.
// Signed operation is built only when DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module div_seq_32b
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t              state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [WIDTH-1:0]        rem_q, rem_d;

  logic signed [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0]        q_q, q_d;
  logic [WIDTH-1:0]        d_q, d_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    neg_a_q, neg_a_d;
  logic                    neg_d_q, neg_d_d;

  logic signed [WIDTH:0]   r_sh;
  logic signed [WIDTH:0]   r_fin;
  logic signed [WIDTH:0]   step_r;
  logic signed [WIDTH:0]   step_r_new;
  logic                    step_sub;
  logic                    step_qbit;

`ifndef DIV_SIGNED_EN
  logic op_signed_unused;
  assign op_signed_unused = op_signed;
`endif

  div_addsub_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (step_r),
    .d     (d_q),
    .sub   (step_sub),
    .r_out (step_r_new),
    .q_bit (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    dbz_d    = dbz_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_d_d  = neg_d_q;
    step_r   = r_q;
    step_sub = 1'b0;
    r_sh     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_fin    = r_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quo_d   = '0;
            rem_d   = dividend;
          end else begin
            state_d = PREP;
            q_d     = dividend;
            d_d     = divisor;
`ifdef DIV_SIGNED_EN
            neg_a_d = op_signed & dividend[WIDTH-1];
            neg_d_d = op_signed & divisor[WIDTH-1];
`else
            neg_a_d = 1'b0;
            neg_d_d = 1'b0;
`endif
          end
        end
      end

      PREP: begin
        // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
`ifdef DIV_SIGNED_EN
        if (neg_a_q) q_d = -q_q;
        if (neg_d_q) d_d = -d_q;
`endif
        r_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
      end

      ITER: begin
        // Add/subtract choice follows the sign of R before the shift.
        step_r   = r_sh;
        step_sub = ~r_q[WIDTH];
        r_d      = step_r_new;
        q_d      = {q_q[WIDTH-2:0], step_qbit};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = FIX;
      end

      FIX: begin
        step_r   = r_q;
        step_sub = 1'b0;
        r_fin    = r_q[WIDTH] ? step_r_new : r_q;
        quo_d    = q_q;
        rem_d    = r_fin[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        if (neg_a_q ^ neg_d_q) quo_d = -q_q;
        if (neg_a_q)           rem_d = -r_fin[WIDTH-1:0];
`endif
        dbz_d    = 1'b0;
        state_d  = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    r_q     <= r_d;
    q_q     <= q_d;
    d_q     <= d_d;
    cnt_q   <= cnt_d;
    neg_a_q <= neg_a_d;
    neg_d_q <= neg_d_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_div_seq_32b.sv
// Scoreboard bench for div_seq_32b: directed corner cases plus randomized divides.
module tb_div_seq_32b;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  div_seq_32b dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_signed   (op_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, wrapped to W bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sg, input int issue);
    exp_t   e;
    logic   use_s;
    longint sa, sd;
    use_s = sg;
`ifndef DIV_SIGNED_EN
    use_s = 1'b0;
`endif
    e.due = issue + ((b == 0) ? 1 : W + 3);
    e.dbz = (b == 0);
    if (b == 0) begin
      e.q = '0;
      e.r = a;
    end else if (use_s) begin
      sa  = longint'($signed(a));
      sd  = longint'($signed(b));
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input bit push, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
    c         = cyc;
    dividend  = a;
    divisor   = b;
    op_signed = sg;
    start     = 1'b1;
    if (push) sb.push_back(model(a, b, sg, cyc));
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    op_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    int c;
    issue(a, b, sg, 1'b1, c);
    wait_done();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bad;
    int n;
    logic [W-1:0] a, b;

    reset = 1'b1; start = 1'b0; op_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    reset = 1'b0;

    // 100/7 with busy window check
    issue(32'd100, 32'd7, 1'b0, 1'b1, c0);
    chk("busy_idle_before", c0 >= 0 ? 0 : 1, 0);
    bad = 0;
    for (int k = 0; k < 34; k++) begin
      if (!busy) bad++;
      @(negedge clk);
    end
    chk("busy_window", bad, 0);
    wait_done();

    run(32'hFFFF_FFF9, 32'd2, 1'b1);
    run(32'd7, 32'hFFFF_FFFE, 1'b1);
    run(32'h0000_1234, 32'd0, 1'b0);
    run(32'd9, 32'd3, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);

    // Start while busy is ignored
    issue(32'd50, 32'd5, 1'b0, 1'b1, c0);
    repeat (9) @(negedge clk);
    dividend = 32'd9; divisor = 32'd4; op_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start in the DONE cycle is ignored
    issue(32'd20, 32'd4, 1'b0, 1'b1, c0);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts with no done pulse
    issue(32'd1000, 32'd3, 1'b0, 1'b0, c0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(32'd77, 32'd5, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run(a, b, 1'($urandom_range(0, 1)));
    end

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
